dht11_frame_formatter: RTL

Downstream consumer of the DHT11 single-wire reader. It accepts one 40-bit sensor frame per valid pulse and verifies the checksum. It converts integer humidity and temperature to 3-digit decimal, then streams an ASCII line byte-by-byte over a valid/ready handshake to the UART transmitter. It also keeps the last good reading and error/overrun counters for debug LEDs.

---
 rtl/dht11_pkg.sv | 36 +++
 rtl/dht11_frame_formatter_bin8_to_bcd.sv | 54 +++++
 rtl/dht11_frame_formatter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared types, ASCII constants and frame layout for the DHT11 formatter
package dht11_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CONV  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h52;

    localparam int MSG_LEN_OK  = 13;
    localparam int MSG_LEN_ERR = 5;

    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CSUM_LSB     = 0;

    function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dht11_frame_formatter_bin8_to_bcd.sv
// rtl/dht11_frame_formatter_bin8_to_bcd.sv - sequential double-dabble, 8-bit binary to 3 BCD digits
module bin8_to_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic [11:0] bcd_o,
    output logic        done_o
);

    // {bcd[11:0], bin[7:0]} shifted left once per cycle after the add-3 correction
    logic [19:0] sr_q, sr_d, adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[8+4*i +: 4] >= 4'd5) begin
                adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
            end
        end
        sr_d  = sr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            sr_d  = {12'h000, bin_i};
            cnt_d = 3'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            sr_d  = {adj[18:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign bcd_o  = sr_q[19:8];
    assign done_o = run_q && (cnt_q == 3'd7);

endmodule

// File: rtl/dht11_frame_formatter.sv
// rtl/dht11_frame_formatter.sv - checksum, decimal conversion and ASCII line streaming of DHT11 frames
module dht11_frame_formatter
    import dht11_pkg::*;
#(
    parameter logic [7:0] HUM_CHAR  = 8'h48,
    parameter logic [7:0] TEMP_CHAR = 8'h54,
    parameter bit         SEND_ERR  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] frame_i,
    input  logic        frame_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        crc_err_o,
    output logic [7:0]  err_cnt_o,
    output logic [7:0]  drop_cnt_o,
    output logic [7:0]  last_hum_o,
    output logic [7:0]  last_temp_o
);

    localparam logic [3:0] LAST_OK  = 4'(MSG_LEN_OK - 1);
    localparam logic [3:0] LAST_ERR = 4'(MSG_LEN_ERR - 1);

    state_e      state_q, state_d;
    logic [39:0] frame_q, frame_d;
    logic [3:0]  idx_q, idx_d;
    logic        err_msg_q, err_msg_d;
    logic [7:0]  err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [7:0]  last_hum_q, last_hum_d, last_temp_q, last_temp_d;

    logic [9:0]  sum10;
    logic        csum_ok, conv_start, hum_done, temp_done, msg_last;
    logic [11:0] hum_bcd, temp_bcd;
    logic [7:0]  byte_sel;

    assign sum10 = {2'b00, frame_q[HUM_INT_LSB +: 8]} + {2'b00, frame_q[HUM_DEC_LSB +: 8]}
                 + {2'b00, frame_q[TEMP_INT_LSB +: 8]} + {2'b00, frame_q[TEMP_DEC_LSB +: 8]};
    assign csum_ok    = (sum10[7:0] == frame_q[CSUM_LSB +: 8]);
    assign conv_start = (state_q == ST_CHECK) && csum_ok;
    assign msg_last   = err_msg_q ? (idx_q == LAST_ERR) : (idx_q == LAST_OK);

    bin8_to_bcd u_hum_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (frame_q[HUM_INT_LSB +: 8]),
        .bcd_o   (hum_bcd),
        .done_o  (hum_done)
    );

    bin8_to_bcd u_temp_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (frame_q[TEMP_INT_LSB +: 8]),
        .bcd_o   (temp_bcd),
        .done_o  (temp_done)
    );

    always_comb begin
        byte_sel = 8'h00;
        if (err_msg_q) begin
            case (idx_q)
                4'd0:    byte_sel = ASCII_E;
                4'd1:    byte_sel = ASCII_R;
                4'd2:    byte_sel = ASCII_R;
                4'd3:    byte_sel = ASCII_CR;
                default: byte_sel = ASCII_LF;
            endcase
        end else begin
            case (idx_q)
                4'd0:    byte_sel = HUM_CHAR;
                4'd1:    byte_sel = ASCII_EQ;
                4'd2:    byte_sel = bcd_ascii(hum_bcd[11:8]);
                4'd3:    byte_sel = bcd_ascii(hum_bcd[7:4]);
                4'd4:    byte_sel = bcd_ascii(hum_bcd[3:0]);
                4'd5:    byte_sel = ASCII_SP;
                4'd6:    byte_sel = TEMP_CHAR;
                4'd7:    byte_sel = ASCII_EQ;
                4'd8:    byte_sel = bcd_ascii(temp_bcd[11:8]);
                4'd9:    byte_sel = bcd_ascii(temp_bcd[7:4]);
                4'd10:   byte_sel = bcd_ascii(temp_bcd[3:0]);
                4'd11:   byte_sel = ASCII_CR;
                default: byte_sel = ASCII_LF;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        err_msg_d   = err_msg_q;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        last_hum_d  = last_hum_q;
        last_temp_d = last_temp_q;
        crc_err_o   = 1'b0;

        // any frame arriving outside IDLE is dropped, even on the final handshake cycle
        if (frame_valid_i && (state_q != ST_IDLE)) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_valid_i) begin
                    frame_d = frame_i;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                idx_d = 4'd0;
                if (csum_ok) begin
                    last_hum_d  = frame_q[HUM_INT_LSB +: 8];
                    last_temp_d = frame_q[TEMP_INT_LSB +: 8];
                    err_msg_d   = 1'b0;
                    state_d     = ST_CONV;
                end else begin
                    crc_err_o = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    err_msg_d = 1'b1;
                    state_d   = SEND_ERR ? ST_SEND : ST_IDLE;
                end
            end
            ST_CONV: begin
                if (hum_done && temp_done) begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                if (tx_ready_i) begin
                    if (msg_last) begin
                        idx_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            idx_q       <= '0;
            err_msg_q   <= 1'b0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            last_hum_q  <= '0;
            last_temp_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            err_msg_q   <= err_msg_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            last_hum_q  <= last_hum_d;
            last_temp_q <= last_temp_d;
        end
    end

    assign tx_valid_o  = (state_q == ST_SEND);
    assign tx_data_o   = (state_q == ST_SEND) ? byte_sel : 8'h00;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_cnt_o   = err_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign last_hum_o  = last_hum_q;
    assign last_temp_o = last_temp_q;

endmodule
